pmu_clk_gate_ctrl: RTL and testbench
====================================

# pmu_clk_gate_ctrl

PMU-side controller that drives the `gate_en0` (CPU clock) and `gate_en1` (peripheral clock) enables consumed by the FPGA clock generator's gating cells. It sequences sleep entry on a CPU sleep request and wake-up on a WIC event, with APB-programmable entry and settle delays. It runs on the ungated `pmu_clk`, so it stays alive while the CPU and peripheral clocks are gated.

## Interface
- SLEEP_DLY_RST, 8'd4: reset value of the entry delay, DLY[7:0].
- WAKE_DLY_RST, 8'd8: reset value of the settle delay, DLY[15:8].
- Clock and reset: one clock, `pmu_clk`; reset `clkrst_b` is asynchronous and active-low. These are fixed.
- pmu_clk  in  1  ungated PMU clock; all flops on rising edge.
- clkrst_b  in  1  asynchronous active-low reset.
- cpu_sleep_req  in  1  level sleep request from the CPU; held high while the CPU is asleep.
- wic_wakeup  in  1  level wake event from the WIC.
- psel, penable, pwrite  in  1 each  APB control; zero wait state.
- paddr  in  4  byte address; only [3:2] decoded.
- pwdata  in  32  APB write data.
- prdata  out  32  APB read data.
- gate_en0  out  1  CPU clock enable; registered.
- gate_en1  out  1  peripheral clock enable; registered.
- pmu_cpu_wakeup  out  1  one-cycle pulse when the CPU clock is re-enabled.

## Operation
- Registers:
  - 0x0 CTRL: [0] deep_en, reset 0. When set, the peripheral clock is also gated.
  - 0x4 DLY: [7:0] entry delay E, [15:8] settle delay S.
  - 0x8 STATUS, read-only: [2:0] state code, [3] armed.
  - Other offsets read 0; writes to them are ignored.
- APB write on `psel && pwrite && penable`, any state. Read: `prdata` is combinational when `psel && !pwrite`, else 32'b0. Unused register bits read 0.
- States and codes: RUN=0, ENTRY=1, CPU_OFF=2, PER_OFF=3, SETTLE=4.
- armed: reset 1. Cleared on every return to RUN from SETTLE. Set in RUN on any cycle with `cpu_sleep_req`=0. Prevents re-entry while the just-woken CPU still holds its request.
- State transitions:
  - RUN -> ENTRY when `armed && cpu_sleep_req && !wic_wakeup`; counter loads E.
  - ENTRY -> RUN (abort) if `!cpu_sleep_req || wic_wakeup`. Abort has priority over expiry. Enables stay 1.
  - ENTRY: when counter == 0 -> CPU_OFF and `gate_en0`<=0; otherwise decrement.
  - CPU_OFF: if `wic_wakeup` -> SETTLE. Else if deep_en -> PER_OFF and `gate_en1`<=0. Else stay.
  - PER_OFF: `wic_wakeup` -> SETTLE and `gate_en1`<=1.
  - SETTLE: counter loads S on entry. When counter == 0 -> RUN, `gate_en0`<=1, `pmu_cpu_wakeup`<=1; otherwise decrement. `wic_wakeup` is ignored here.
- deep_en is sampled only in CPU_OFF. Clearing it during PER_OFF has no effect until wake-up.
- Reset values: state RUN, `gate_en0`=1, `gate_en1`=1, `pmu_cpu_wakeup`=0, `prdata`=0, CTRL=0, DLY={WAKE_DLY_RST,SLEEP_DLY_RST}.
- Reset asserted mid-sequence returns immediately to RUN with both enables at 1.

## Timing
- Entry: if `cpu_sleep_req` is first sampled high at edge t, `gate_en0` falls at edge t+E+1.
  - With deep_en set, `gate_en1` falls at t+E+2.
  - E=0 gives the minimum: `gate_en0` low at t+1.
- Wake: if `wic_wakeup` is sampled high at edge w in CPU_OFF or PER_OFF, then:
  - `gate_en1`=1 from edge w.
  - `gate_en0` rises and `pmu_cpu_wakeup` pulses at edge w+S+1.
  - `pmu_cpu_wakeup` is high for exactly one cycle.
- The downstream gating cell adds one further cycle; this block does not compensate for it.
- Counters are 8-bit, down-counting, with no wrap. A value of 255 gives a 256-cycle wait.

## Configuration
- `PMU_DEEP_SLEEP_EN` defined:
  - deep_en is implemented.
  - PER_OFF is reachable.
  - `gate_en1` behaves as above.
- Not defined:
  - CTRL[0] is not stored and reads 0.
  - PER_OFF is removed.
  - `gate_en1` is a constant 1.

## Test plan
- Reset, read 0x4 -> 0x0000_0804; `gate_en0`=`gate_en1`=1; STATUS=0x8.
- E=4, deep_en=0, hold `cpu_sleep_req` high from edge t -> `gate_en0`=0 at t+5; `gate_en1` stays 1; STATUS=0x2+0x8.
- deep_en=1, E=0, S=3; sleep, then pulse `wic_wakeup` at edge w -> `gate_en1`=1 at w; `gate_en0`=1 and `pmu_cpu_wakeup` pulse at w+4.
- After wake, keep `cpu_sleep_req` high for 10 cycles -> no re-entry (STATUS=0x0). Drop it for 1 cycle, then raise it -> ENTRY.
- E=6, raise `cpu_sleep_req`, then assert `wic_wakeup` on the exact expiry cycle -> abort to RUN; `gate_en0` never drops.
- Assert `clkrst_b` during SETTLE -> RUN; both enables 1; no `pmu_cpu_wakeup` pulse.

Source files
------------

// File: rtl/pmu_clk_gate_ctrl.sv
// pmu_clk_gate_ctrl: sleep-entry / wake-up sequencer driving the CPU and peripheral clock-gate enables.
// Define PMU_DEEP_SLEEP_EN to implement CTRL.deep_en and peripheral-clock gating (PER_OFF).
module pmu_clk_gate_ctrl #(
    parameter logic [7:0] SLEEP_DLY_RST = 8'd4,
    parameter logic [7:0] WAKE_DLY_RST  = 8'd8
) (
    input  logic        pmu_clk,
    input  logic        clkrst_b,
    input  logic        cpu_sleep_req,
    input  logic        wic_wakeup,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [3:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        gate_en0,
    output logic        gate_en1,
    output logic        pmu_cpu_wakeup
);
    typedef enum logic [2:0] {
        RUN     = 3'd0,
        ENTRY   = 3'd1,
        CPU_OFF = 3'd2,
        PER_OFF = 3'd3,
        SETTLE  = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] dly_q, dly_d;
    logic        armed_q, armed_d;
    logic        gate0_q, gate0_d;
    logic        wake_q, wake_d;
    logic        deep_en;
    logic        wr;
    logic        unused_ok;

    assign wr        = psel && pwrite && penable;
    assign unused_ok = ^{pwdata[31:16], paddr[1:0]};
    assign dly_d     = (wr && paddr[3:2] == 2'd1) ? pwdata[15:0] : dly_q;

`ifdef PMU_DEEP_SLEEP_EN
    logic deep_q, deep_d;
    logic gate1_q, gate1_d;
    assign deep_d   = (wr && paddr[3:2] == 2'd0) ? pwdata[0] : deep_q;
    assign deep_en  = deep_q;
    assign gate_en1 = gate1_q;
    always_ff @(posedge pmu_clk or negedge clkrst_b) begin
        if (!clkrst_b) begin
            deep_q  <= 1'b0;
            gate1_q <= 1'b1;
        end else begin
            deep_q  <= deep_d;
            gate1_q <= gate1_d;
        end
    end
`else
    assign deep_en  = 1'b0;
    assign gate_en1 = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        gate0_d = gate0_q;
        wake_d  = 1'b0;
`ifdef PMU_DEEP_SLEEP_EN
        gate1_d = gate1_q;
`endif
        case (state_q)
            RUN: begin
                armed_d = armed_q || !cpu_sleep_req;
                if (armed_q && cpu_sleep_req && !wic_wakeup) begin
                    state_d = ENTRY;
                    cnt_d   = dly_q[7:0];
                end
            end
            // abort outranks expiry so a late wake never gates the CPU
            ENTRY: begin
                if (!cpu_sleep_req || wic_wakeup) begin
                    state_d = RUN;
                end else if (cnt_q == 8'd0) begin
                    state_d = CPU_OFF;
                    gate0_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            CPU_OFF: begin
                if (wic_wakeup) begin
                    state_d = SETTLE;
                    cnt_d   = dly_q[15:8];
`ifdef PMU_DEEP_SLEEP_EN
                end else if (deep_en) begin
                    state_d = PER_OFF;
                    gate1_d = 1'b0;
`endif
                end
            end
`ifdef PMU_DEEP_SLEEP_EN
            PER_OFF: begin
                if (wic_wakeup) begin
                    state_d = SETTLE;
                    cnt_d   = dly_q[15:8];
                    gate1_d = 1'b1;
                end
            end
`endif
            SETTLE: begin
                if (cnt_q == 8'd0) begin
                    state_d = RUN;
                    gate0_d = 1'b1;
                    wake_d  = 1'b1;
                    armed_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge pmu_clk or negedge clkrst_b) begin
        if (!clkrst_b) begin
            state_q <= RUN;
            cnt_q   <= 8'd0;
            dly_q   <= {WAKE_DLY_RST, SLEEP_DLY_RST};
            armed_q <= 1'b1;
            gate0_q <= 1'b1;
            wake_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dly_q   <= dly_d;
            armed_q <= armed_d;
            gate0_q <= gate0_d;
            wake_q  <= wake_d;
        end
    end

    assign gate_en0       = gate0_q;
    assign pmu_cpu_wakeup = wake_q;
    assign prdata = !(psel && !pwrite)  ? 32'b0 :
                    paddr[3:2] == 2'd0 ? {31'b0, deep_en} :
                    paddr[3:2] == 2'd1 ? {16'b0, dly_q} :
                    paddr[3:2] == 2'd2 ? {28'b0, armed_q, state_q} : 32'b0;
endmodule

// File: tb/tb_pmu_clk_gate_ctrl.sv
// tb_pmu_clk_gate_ctrl: directed bench with an edge-timestamp model of the sleep/wake sequencer.
module tb_pmu_clk_gate_ctrl;
    logic        pmu_clk = 1'b0;
    logic        clkrst_b = 1'b0;
    logic        cpu_sleep_req = 1'b0, wic_wakeup = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [3:0]  paddr = 4'd0;
    logic [31:0] pwdata = 32'd0;
    logic [31:0] prdata;
    logic        gate_en0, gate_en1, pmu_cpu_wakeup;

    int checks = 0, errors = 0;
    int n = 0;
    int wk_cnt = 0, g0_low_cnt = 0;

    pmu_clk_gate_ctrl dut (
        .pmu_clk(pmu_clk), .clkrst_b(clkrst_b),
        .cpu_sleep_req(cpu_sleep_req), .wic_wakeup(wic_wakeup),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .gate_en0(gate_en0), .gate_en1(gate_en1), .pmu_cpu_wakeup(pmu_cpu_wakeup)
    );

    always #5 pmu_clk = ~pmu_clk;

`ifdef PMU_DEEP_SLEEP_EN
    localparam bit DEEP = 1'b1;
`else
    localparam bit DEEP = 1'b0;
`endif

    // Model: phase 0 run, 1 entering, 2 cpu off, 3 peripheral off, 4 settling; dl is the edge number of the next timed event.
    int          ph = 0, dl = 0;
    bit          m_armed = 1'b1, m_g0 = 1'b1, m_g1 = 1'b1, m_wk = 1'b0, m_deep = 1'b0;
    logic [15:0] m_dly = 16'h0804;

    always @(posedge pmu_clk or negedge clkrst_b) begin
        if (!clkrst_b) begin
            ph = 0; m_armed = 1'b1; m_g0 = 1'b1; m_g1 = 1'b1; m_wk = 1'b0; m_deep = 1'b0; m_dly = 16'h0804;
        end else begin
            n++;
            m_wk = 1'b0;
            if (ph == 0) begin
                if (m_armed && cpu_sleep_req && !wic_wakeup) begin ph = 1; dl = n + int'(m_dly[7:0]) + 1; end
                if (!cpu_sleep_req) m_armed = 1'b1;
            end else if (ph == 1) begin
                if (!cpu_sleep_req || wic_wakeup) ph = 0;
                else if (n == dl) begin ph = 2; m_g0 = 1'b0; end
            end else if ((ph == 2 || ph == 3) && wic_wakeup) begin
                ph = 4; dl = n + int'(m_dly[15:8]) + 1; m_g1 = 1'b1;
            end else if (ph == 2 && m_deep) begin
                ph = 3; m_g1 = 1'b0;
            end else if (ph == 4 && n == dl) begin
                ph = 0; m_g0 = 1'b1; m_wk = 1'b1; m_armed = 1'b0;
            end
            if (psel && pwrite && penable) begin
                if (paddr[3:2] == 2'd1) m_dly = pwdata[15:0];
                if (paddr[3:2] == 2'd0 && DEEP) m_deep = pwdata[0];
            end
        end
    end

    function automatic logic [31:0] m_rd(input logic [3:0] a);
        case (a[3:2])
            2'd0:    return {31'b0, m_deep};
            2'd1:    return {16'b0, m_dly};
            2'd2:    return {28'b0, m_armed, 3'(ph)};
            default: return 32'b0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at edge %0d", nm, got, exp, n);
        end
    endtask

    always @(posedge pmu_clk) begin
        #1;
        chk("gate_en0", 32'(gate_en0), 32'(m_g0));
        chk("gate_en1", 32'(gate_en1), 32'(m_g1));
        chk("wakeup", 32'(pmu_cpu_wakeup), 32'(m_wk));
        chk("prdata", prdata, (psel && !pwrite) ? m_rd(paddr) : 32'b0);
        if (pmu_cpu_wakeup) wk_cnt++;
        if (!gate_en0) g0_low_cnt++;
    end

    task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge pmu_clk); psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
        @(negedge pmu_clk); penable = 1'b1;
        @(negedge pmu_clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge pmu_clk); psel = 1'b1; pwrite = 1'b0; paddr = a;
        @(posedge pmu_clk); #1; d = prdata;
        @(negedge pmu_clk); psel = 1'b0;
    endtask

    task automatic wait_g0(input logic lvl, output int at);
        at = -1;
        for (int i = 0; i < 400 && at < 0; i++) begin
            @(posedge pmu_clk); #1;
            if (gate_en0 == lvl) at = n;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int t, w, at, snap;
        repeat (3) @(negedge pmu_clk);
        clkrst_b = 1'b1;
        apb_read(4'h4, d);  chk("rst_dly", d, 32'h0000_0804);
        apb_read(4'h8, d);  chk("rst_status", d, 32'h8);
        chk("rst_g0", 32'(gate_en0), 32'd1);
        chk("rst_g1", 32'(gate_en1), 32'd1);

        apb_write(4'h0, 32'd0);
        @(negedge pmu_clk); cpu_sleep_req = 1'b1; t = n + 1;
        wait_g0(1'b0, at);  chk("entry_e4", 32'(at), 32'(t + 5));
        apb_read(4'h8, d);  chk("status_cpu_off", d, 32'hA);
        chk("g1_shallow", 32'(gate_en1), 32'd1);
        @(negedge pmu_clk); wic_wakeup = 1'b1; w = n + 1;
        @(negedge pmu_clk); wic_wakeup = 1'b0;
        wait_g0(1'b1, at);  chk("wake_s8", 32'(at), 32'(w + 9));
        chk("wake_pulse_s8", 32'(pmu_cpu_wakeup), 32'd1);
        repeat (10) @(negedge pmu_clk);
        apb_read(4'h8, d);  chk("no_reentry", d, 32'h0);
        @(negedge pmu_clk); cpu_sleep_req = 1'b0;
        @(negedge pmu_clk); cpu_sleep_req = 1'b1;
        apb_read(4'h8, d);  chk("rearm_entry", d, 32'h9);
        @(negedge pmu_clk); cpu_sleep_req = 1'b0;

        apb_write(4'h4, 32'h0000_0300);
        apb_write(4'h0, 32'h1);
        apb_read(4'h0, d);  chk("ctrl_rd", d, DEEP ? 32'h1 : 32'h0);
        @(negedge pmu_clk); cpu_sleep_req = 1'b1; t = n + 1;
        wait_g0(1'b0, at);  chk("entry_e0", 32'(at), 32'(t + 1));
        @(posedge pmu_clk); #1;
        chk("g1_deep", 32'(gate_en1), DEEP ? 32'd0 : 32'd1);
        apb_read(4'h8, d);  chk("status_deep", d, DEEP ? 32'hB : 32'hA);
        @(negedge pmu_clk); wic_wakeup = 1'b1; w = n + 1;
        @(posedge pmu_clk); #1;
        chk("g1_at_w", 32'(gate_en1), 32'd1);
        @(negedge pmu_clk); wic_wakeup = 1'b0;
        wait_g0(1'b1, at);  chk("wake_s3", 32'(at), 32'(w + 4));
        chk("wake_pulse_s3", 32'(pmu_cpu_wakeup), 32'd1);
        @(posedge pmu_clk); #1;
        chk("wake_one_cycle", 32'(pmu_cpu_wakeup), 32'd0);
        @(negedge pmu_clk); cpu_sleep_req = 1'b0;

        apb_write(4'h0, 32'h0);
        apb_write(4'h4, 32'h0000_0806);
        repeat (2) @(negedge pmu_clk);
        snap = g0_low_cnt;
        @(negedge pmu_clk); cpu_sleep_req = 1'b1;
        repeat (7) @(negedge pmu_clk);
        wic_wakeup = 1'b1;
        @(negedge pmu_clk); wic_wakeup = 1'b0; cpu_sleep_req = 1'b0;
        repeat (5) @(negedge pmu_clk);
        chk("abort_no_drop", 32'(g0_low_cnt - snap), 32'd0);
        apb_read(4'h8, d);  chk("abort_status", d, 32'h8);

        apb_write(4'h4, 32'h0000_0800);
        @(negedge pmu_clk); cpu_sleep_req = 1'b1;
        wait_g0(1'b0, at);
        @(negedge pmu_clk); wic_wakeup = 1'b1;
        @(negedge pmu_clk); wic_wakeup = 1'b0; cpu_sleep_req = 1'b0;
        repeat (2) @(negedge pmu_clk);
        snap = wk_cnt;
        clkrst_b = 1'b0;
        #1;
        chk("rst_mid_g0", 32'(gate_en0), 32'd1);
        chk("rst_mid_g1", 32'(gate_en1), 32'd1);
        apb_read(4'h8, d);  chk("rst_mid_status", d, 32'h8);
        @(negedge pmu_clk); clkrst_b = 1'b1;
        repeat (15) @(negedge pmu_clk);
        chk("rst_no_pulse", 32'(wk_cnt - snap), 32'd0);
        apb_read(4'h4, d);  chk("rst_mid_dly", d, 32'h0000_0804);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
